// File: rtl/bcd_count_pkg.sv
// bcd_count_pkg: shared digit width, digit type and terminal-value helper for the BCD count chain
package bcd_count_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  // Value a digit must hold to pass a step on: radix-1 counting up, 0 counting down.
  function automatic digit_t term_val(input logic up, input int radix);
    return up ? digit_t'(radix - 1) : '0;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one modulo-RADIX up/down digit
//   clk, clear (sync active-high), load/load_d (preset), step (advance this cycle), up (direction)
//   q (digit value), at_term (digit sits at its terminal value for the current direction)
module bcd_digit import bcd_count_pkg::*; #(
  parameter int RADIX = 10
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   load,
  input  digit_t load_d,
  input  logic   step,
  input  logic   up,
  output digit_t q,
  output logic   at_term
);
  localparam digit_t RMAX = digit_t'(RADIX - 1);
  digit_t nxt;
  always_comb nxt = up ? (q == RMAX ? '0 : digit_t'(q + 4'd1)) : (q == '0 ? RMAX : digit_t'(q - 4'd1));
  assign at_term = q == term_val(up, RADIX);
  // Out-of-range preset nibbles are forced to 0 so an illegal digit can never be held.
  always_ff @(posedge clk)
    q <= clear ? '0 : load ? (load_d > RMAX ? '0 : load_d) : step ? nxt : q;
endmodule

// File: rtl/bcd_count_chain.sv
// bcd_count_chain: DIGITS-digit modulo-RADIX up/down counter with preset, snapshot and sticky overflow
//   clk, clear (sync active-high), en (count), up (direction), load/load_val (preset),
//   latch (snapshot to dout_hold); dout (live count), dout_hold, co (terminal carry/borrow), ovf
module bcd_count_chain import bcd_count_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      latch,
  output logic [DIGIT_W*DIGITS-1:0] dout,
  output logic [DIGIT_W*DIGITS-1:0] dout_hold,
  output logic                      co,
  output logic                      ovf
);
  logic [DIGITS-1:0] step, at_term;
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      // A digit steps only when every lower digit is at its terminal value.
      if (k == 0) begin : g_lsd
        assign step[k] = en;
      end else begin : g_upper
        assign step[k] = step[k-1] & at_term[k-1];
      end
      bcd_digit #(.RADIX(RADIX)) u_dig (
        .clk(clk),
        .clear(clear),
        .load(load),
        .load_d(load_val[k*DIGIT_W +: DIGIT_W]),
        .step(step[k]),
        .up(up),
        .q(dout[k*DIGIT_W +: DIGIT_W]),
        .at_term(at_term[k])
      );
    end
  endgenerate
  // Flat compare keeps co off the ripple step chain.
  assign co = en & (&at_term);
  // dout_hold samples the pre-edge count, so a same-cycle step or load is not captured.
  always_ff @(posedge clk)
    if (clear) begin
      dout_hold <= '0;
      ovf       <= 1'b0;
    end else begin
      if (latch) dout_hold <= dout;
      ovf <= load ? 1'b0 : (co | ovf);
    end
endmodule

// File: tb/tb_bcd_count_chain.sv
// tb_bcd_count_chain: scoreboard bench for bcd_count_chain (4x decade and 2x hex instances)
module tb_bcd_count_chain;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, latch = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] dout, dout_hold;
  logic co, ovf;

  logic b_clear = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0, b_latch = 1'b0;
  logic [7:0] b_lv = '0;
  logic [7:0] b_dout, b_hold;
  logic b_co, b_ovf;

  bcd_count_chain #(.DIGITS(4), .RADIX(10)) dut (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .latch(latch), .dout(dout), .dout_hold(dout_hold), .co(co), .ovf(ovf)
  );

  bcd_count_chain #(.DIGITS(2), .RADIX(16)) dut_hex (
    .clk(clk), .clear(b_clear), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .latch(b_latch), .dout(b_dout), .dout_hold(b_hold), .co(b_co), .ovf(b_ovf)
  );

  int n_tests = 0, n_fail = 0, co_hits = 0;
  int m_cnt = 0, m_hold = 0;
  logic m_ovf = 1'b0;
  typedef struct { logic [15:0] d; logic [15:0] h; logic o; } exp_t;
  exp_t q_a[$];
  logic [7:0] q_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_val(input logic [15:0] v);
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      int nib = int'(v[4*i +: 4]);
      n = n * 10 + (nib >= 10 ? 0 : nib);
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic cyc(input logic c, input logic ld, input logic e, input logic u, input logic lt,
                     input logic [15:0] lv);
    exp_t x;
    logic ec;
    @(negedge clk);
    clear = c; load = ld; en = e; up = u; latch = lt; load_val = lv;
    #1;
    ec = e && (u ? m_cnt == 9999 : m_cnt == 0);
    chk("co", co, ec);
    co_hits += int'(co);
    if (c) begin
      m_cnt = 0; m_hold = 0; m_ovf = 1'b0;
    end else begin
      if (lt) m_hold = m_cnt;
      if (ld) begin
        m_cnt = to_val(lv); m_ovf = 1'b0;
      end else begin
        if (ec) m_ovf = 1'b1;
        if (e) m_cnt = u ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
      end
    end
    q_a.push_back('{to_bcd(m_cnt), to_bcd(m_hold), m_ovf});
    @(posedge clk);
    #1;
    x = q_a.pop_front();
    chk("dout", dout, x.d);
    chk("hold", dout_hold, x.h);
    chk("ovf", ovf, x.o);
  endtask

  task automatic bcyc(input logic ld, input logic e, input logic [7:0] lv, input logic ec,
                      input logic [7:0] ed);
    @(negedge clk);
    b_clear = 1'b0; b_load = ld; b_en = e; b_lv = lv;
    #1;
    chk("hex_co", b_co, ec);
    q_b.push_back(ed);
    @(posedge clk);
    #1;
    chk("hex_dout", b_dout, q_b.pop_front());
  endtask

  initial begin
    cyc(1, 0, 0, 1, 0, 16'h0);
    chk("rst_dout", dout, 16'h0);
    chk("rst_ovf", ovf, 0);
    co_hits = 0;
    for (int i = 0; i < 10000; i++) cyc(0, 0, 1, 1, 0, 16'h0);
    chk("wrap_dout", dout, 16'h0);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_co_hits", co_hits, 1);
    cyc(0, 1, 0, 0, 0, 16'h0100);
    cyc(0, 0, 1, 0, 0, 16'h0);
    chk("borrow_dout", dout, 16'h0099);
    chk("borrow_ovf", ovf, 0);
    cyc(0, 1, 1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 0, 0, 16'h0);
    chk("under_dout", dout, 16'h9999);
    chk("under_ovf", ovf, 1);
    cyc(1, 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 42; i++) cyc(0, 0, 1, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 1, 16'h0);
    chk("snap_hold", dout_hold, 16'h0042);
    chk("snap_dout", dout, 16'h0043);
    cyc(0, 1, 0, 1, 0, 16'h1234);
    cyc(1, 1, 0, 1, 1, 16'h5678);
    chk("clr_dout", dout, 16'h0);
    chk("clr_hold", dout_hold, 16'h0);
    cyc(0, 1, 0, 1, 0, 16'h00A5);
    chk("illegal_load", dout, 16'h0005);
    cyc(0, 1, 1, 1, 1, 16'h0777);
    chk("ldlatch_hold", dout_hold, 16'h0005);
    chk("ldlatch_dout", dout, 16'h0777);
    cyc(1, 0, 1, 1, 0, 16'h0);
    cyc(0, 0, 1, 1, 0, 16'h0);
    chk("resume_dout", dout, 16'h0001);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
          1'($urandom_range(1)), $urandom_range(7) == 0, 16'($urandom));
    cyc(0, 1, 0, 1, 0, 16'h9997);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 16'h0);
    cyc(0, 0, 0, 1, 0, 16'h0);
    bcyc(1, 0, 8'hFE, 0, 8'hFE);
    bcyc(0, 1, 8'h00, 0, 8'hFF);
    bcyc(0, 1, 8'h00, 1, 8'h00);
    for (int i = 0; i < 5; i++) bcyc(0, 0, 8'h00, 0, 8'h00);
    chk("hex_ovf", b_ovf, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_count_chain.md
# bcd_count_chain

Parametrised multi-digit BCD event counter for the frequency and pulse measurement path; the generalised successor of the single-decade counter. It counts up or down with one enable for the whole chain, ripples carry and borrow across `DIGITS` digits, supports a synchronous preset load, and captures a snapshot into a holding register at the end of each gate period. A sticky overflow flag marks any wrap past the full-scale value.

## Interface
- `DIGITS`, default 4: number of digits, 1..8.
- `RADIX`, default 10: modulus of each digit, 2..16. Each digit is 4 bits wide regardless of radix.
- `clk` in 1: single clock; all state changes on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `en` in 1: count enable, one step per cycle.
- `up` in 1: direction select; 1 counts up, 0 counts down. Sampled only when `en`=1.
- `load` in 1: synchronous preset of the live count from `load_val`.
- `load_val` in 4*DIGITS: preset value, one digit per nibble, digit 0 in [3:0].
- `latch` in 1: copies the live count into `dout_hold`.
- `dout` out 4*DIGITS: live count, registered.
- `dout_hold` out 4*DIGITS: last latched count, registered.
- `co` out 1: terminal carry or borrow for cascading, combinational from registered state.
- `ovf` out 1: sticky overflow or underflow flag, registered.

## Operation
- Priority for the live count: `clear` > `load` > `en`. With none of these active, the count holds.
- `clear`=1: all digits, `dout_hold` and `ovf` go to 0 on the next edge. This overrides `latch` in the same cycle.
- `load`=1: each digit takes its `load_val` nibble. A nibble ≥ `RADIX` is stored as 0. `ovf` is cleared. `en` is ignored in that cycle.
- Counting up, `en`=1 and `up`=1:
  - Digit 0 increments.
  - Digit k steps only when all lower digits equal `RADIX`-1. A digit at `RADIX`-1 that steps wraps to 0.
- Counting down, `en`=1 and `up`=0:
  - Digit 0 decrements.
  - Digit k steps only when all lower digits equal 0. A digit at 0 that steps wraps to `RADIX`-1.
- Digits never change while `en`=0. This fixes the earlier decade counter's habit of wrapping at 9 without enable.
- `co` = `en` AND (up ? all digits == `RADIX`-1 : all digits == 0). It is qualified by `en`, so a downstream chain steps exactly once per wrap.
- `ovf` sets on any edge where `co`=1 and there is no `clear` or `load`. It stays set until `clear` or `load`.
- `latch`=1 without `clear`: `dout_hold` takes the count value before this edge's step. A simultaneous `en` therefore does not appear in the snapshot.
- Same-cycle `latch` and `load`: `dout_hold` takes the pre-load count.
- An illegal digit value (≥ `RADIX`) cannot arise from counting or loading. No recovery logic is required.

## Timing
- Reset values: `dout`=0, `dout_hold`=0, `ovf`=0. `co`=0 after reset whenever `up`=1. With `up`=0 and `en`=1, `co`=1 immediately, because all digits are 0.
- Count latency: a step requested at edge n is visible on `dout` after edge n.
- Load latency: 1 cycle. Latch latency: 1 cycle.
- `co` is combinational with no register stage. The path is the `DIGITS`-wide compare plus the AND with `en`. With `DIGITS`=8 it must close at the system clock.
- Deasserting `clear` in the middle of a gate period resumes counting on the first edge with `clear`=0 and `en`=1.
- Direction may change on any cycle. It takes effect on the same edge.

## Structure
- Shared package `bcd_count_pkg`:
  - constant `DIGIT_W`=4;
  - function `term_val(up, radix)`, returning `RADIX`-1 or 0;
  - typedef for a digit nibble.
- Sub-module `bcd_digit`, instantiated `DIGITS` times:
  - inputs: `clk`, `clear`, `load`, `load_d`, `step`, `up`;
  - outputs: `q`, plus `at_term`, the terminal flag for the current direction.
- Top level:
  - generate loop building the `step` chain as `step[k]` = `en` AND all lower `at_term`;
  - holding register, `ovf` flop and `co` logic.

## Test plan
- `DIGITS`=4, `RADIX`=10, `clear`, then 10000 cycles of `en`=1, `up`=1 → `dout`=0x0000, `co` high for exactly 1 cycle when `dout`=0x9999, `ovf`=1 afterwards.
- Load 0x0100 with `up`=0, then one `en` cycle → `dout`=0x0099, `co`=0. Load 0x0000 with `up`=0 and `en`=1 → `co`=1, next `dout`=0x9999, `ovf`=1.
- Count to 0x0042, then assert `latch` with `en`=1 in the same cycle → `dout_hold`=0x0042, `dout`=0x0043.
- `clear`, `load` and `latch` all asserted in the same cycle while `dout`=0x1234 → `dout`=0, `dout_hold`=0, `ovf`=0. Load 0x00A5 → `dout`=0x0005.
- `RADIX`=16, `DIGITS`=2, counting up from 0xFE for 2 enabled cycles, then `en`=0 for 5 cycles → `dout` sequence 0xFF, 0x00, then holds at 0x00. `co` is high only in the 0xFF cycle.
- `DIGITS`=4, `RADIX`=10, `clear` deasserted mid-count with `en`=1 → `dout`=0x0001 after the first post-reset edge.
